// File: rtl/pcss_pkg.sv
// rtl/pcss_pkg.sv - shared state encoding and default timing constants for the timestep scheduler
package pcss_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int TIK_CNT    = 8;
  localparam int TIK_LEN    = 7;
  localparam int DRAIN_CYC  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_SPK,
    ST_DRAIN,
    ST_TIK,
    ST_DONE
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pcss_step_sched_if.sv
// rtl/pcss_step_sched_if.sv - one stream channel (tdata/tvalid/tready/tlast/tkeep)
interface pcss_step_sched_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;
  logic [DATA_WIDTH/8-1:0] tkeep;

  modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);
endinterface

// File: rtl/pcss_cyc_timer.sv
// rtl/pcss_cyc_timer.sv - loadable down-counter; expire is high in the last counted cycle
module pcss_cyc_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // A load on the expiring cycle wins, so DRAIN can chain straight into TIK.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pcss_step_sched.sv
// rtl/pcss_step_sched.sv - muxes cfg/spike streams onto one output and paces spike frames with tik pulses
module pcss_step_sched
  import pcss_pkg::*;
#(
  parameter int DATA_WIDTH = pcss_pkg::DATA_WIDTH,
  parameter int TIK_CNT    = pcss_pkg::TIK_CNT,
  parameter int TIK_LEN    = pcss_pkg::TIK_LEN,
  parameter int DRAIN_CYC  = pcss_pkg::DRAIN_CYC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                cfg_en,
  input  logic [TIK_CNT-1:0]  num_steps,
  pcss_step_sched_if.slave    s_cfg,
  pcss_step_sched_if.slave    s_spk,
  pcss_step_sched_if.master   m,
  output logic                tik,
  output logic [TIK_CNT-1:0]  step_cnt,
  output logic                busy,
  output logic                done
);

  localparam int TMR_W = $clog2(max_int(TIK_LEN, DRAIN_CYC) + 1);

  state_e               state_q, state_d;
  logic [TIK_CNT-1:0]   num_steps_q, num_steps_d;
  logic [TIK_CNT-1:0]   step_cnt_q, step_cnt_d;
  logic                 tik_q, tik_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 tmr_load;
  logic [TMR_W-1:0]     tmr_val;
  logic                 tmr_expire;
  logic                 cfg_last_fire;
  logic                 spk_last_fire;

  // Zero-latency pass-through of whichever source the FSM currently owns.
  always_comb begin
    m.tdata      = {DATA_WIDTH{1'b0}};
    m.tkeep      = {(DATA_WIDTH/8){1'b0}};
    m.tvalid     = 1'b0;
    m.tlast      = 1'b0;
    s_cfg.tready = 1'b0;
    s_spk.tready = 1'b0;
    case (state_q)
      ST_CFG: begin
        m.tdata      = s_cfg.tdata;
        m.tkeep      = s_cfg.tkeep;
        m.tvalid     = s_cfg.tvalid;
        m.tlast      = s_cfg.tlast;
        s_cfg.tready = m.tready;
      end
      ST_SPK: begin
        m.tdata      = s_spk.tdata;
        m.tkeep      = s_spk.tkeep;
        m.tvalid     = s_spk.tvalid;
        m.tlast      = s_spk.tlast;
        s_spk.tready = m.tready;
      end
      default: ;
    endcase
  end

  assign cfg_last_fire = (state_q == ST_CFG) && s_cfg.tvalid && m.tready && s_cfg.tlast;
  assign spk_last_fire = (state_q == ST_SPK) && s_spk.tvalid && m.tready && s_spk.tlast;

  always_comb begin
    state_d     = state_q;
    num_steps_d = num_steps_q;
    step_cnt_d  = step_cnt_q;
    tik_d       = tik_q;
    tmr_load    = 1'b0;
    tmr_val     = TMR_W'(DRAIN_CYC);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          num_steps_d = num_steps;
          step_cnt_d  = '0;
          if (cfg_en)                 state_d = ST_CFG;
          else if (num_steps != '0)   state_d = ST_SPK;
          else                        state_d = ST_DONE;
        end
      end
      ST_CFG: begin
        if (cfg_last_fire) state_d = (num_steps_q != '0) ? ST_SPK : ST_DONE;
      end
      ST_SPK: begin
        if (spk_last_fire) begin
          state_d  = ST_DRAIN;
          tmr_load = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (tmr_expire) begin
          state_d  = ST_TIK;
          tik_d    = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(TIK_LEN);
        end
      end
      ST_TIK: begin
        if (tmr_expire) begin
          tik_d      = 1'b0;
          step_cnt_d = step_cnt_q + 1'b1;
          state_d    = (step_cnt_d == num_steps_q) ? ST_DONE : ST_SPK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_CFG) || (state_d == ST_SPK) || (state_d == ST_DRAIN) || (state_d == ST_TIK);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      num_steps_q <= '0;
      step_cnt_q  <= '0;
      tik_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_steps_q <= num_steps_d;
      step_cnt_q  <= step_cnt_d;
      tik_q       <= tik_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  pcss_cyc_timer #(.W(TMR_W)) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  assign tik      = tik_q;
  assign step_cnt = step_cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_pcss_step_sched.sv
// tb/tb_pcss_step_sched.sv - self-checking bench for pcss_step_sched
module tb_pcss_step_sched;
  import pcss_pkg::*;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    bit cfg_en;
    int n;
    int cb;
    int sb;
    int mode;
    bit inject;
    int exp_beats;
    int exp_tiks;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       cfg_en;
  logic [7:0] num_steps;
  logic       tik, busy, done;
  logic [7:0] step_cnt;

  pcss_step_sched_if #(.DATA_WIDTH(64)) s_cfg ();
  pcss_step_sched_if #(.DATA_WIDTH(64)) s_spk ();
  pcss_step_sched_if #(.DATA_WIDTH(64)) m ();

  pcss_step_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_en    (cfg_en),
    .num_steps (num_steps),
    .s_cfg     (s_cfg),
    .s_spk     (s_spk),
    .m         (m),
    .tik       (tik),
    .step_cnt  (step_cnt),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  beat_t cfg_q[$], spk_q[$], exp_q[$];
  int    n_pass = 0, n_total = 0;
  int    cyc = 0, obs_beats, tik_cnt, tik_w, last_tlast_cyc;
  int    mode = 0;
  bit    tik_prev, mon_en = 0, spk_in_cfg, cfg_fire = 0, spk_fire = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Observer: scoreboard of output beats and tik timing, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    cfg_fire = s_cfg.tvalid && s_cfg.tready;
    spk_fire = s_spk.tvalid && s_spk.tready;
    if (mon_en) begin
      if (m.tvalid && m.tready) begin
        obs_beats++;
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else begin
          check("beat_data", m.tdata, exp_q[0].data);
          check("beat_keep", m.tkeep, exp_q[0].keep);
          check("beat_last", m.tlast, exp_q[0].last);
          exp_q.delete(0);
        end
      end
      if (s_spk.tready && exp_q.size() > 0 && exp_q[0].data[63:56] == 8'hCF) spk_in_cfg = 1;
      if (spk_fire && s_spk.tlast) last_tlast_cyc = cyc;
      if (tik && !tik_prev) begin
        check("drain_gap", cyc - last_tlast_cyc, DRAIN_CYC + 1);
        tik_w = 0;
      end
      if (tik) tik_w++;
      if (!tik && tik_prev) begin
        tik_cnt++;
        check("tik_width", tik_w, TIK_LEN);
        check("step_cnt_at_fall", step_cnt, tik_cnt);
      end
      tik_prev = tik;
    end
  end

  // Source and sink drivers, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (cfg_fire && cfg_q.size() > 0) cfg_q.delete(0);
    if (spk_fire && spk_q.size() > 0) spk_q.delete(0);
    cfg_fire = 0;
    spk_fire = 0;
    if (cfg_q.size() > 0 && (mode != 2 || s_cfg.tvalid || $urandom_range(3) != 0)) begin
      s_cfg.tvalid = 1'b1; s_cfg.tdata = cfg_q[0].data; s_cfg.tkeep = cfg_q[0].keep; s_cfg.tlast = cfg_q[0].last;
    end else begin
      s_cfg.tvalid = 1'b0; s_cfg.tdata = '0; s_cfg.tkeep = '0; s_cfg.tlast = 1'b0;
    end
    if (spk_q.size() > 0 && (mode != 2 || s_spk.tvalid || $urandom_range(3) != 0)) begin
      s_spk.tvalid = 1'b1; s_spk.tdata = spk_q[0].data; s_spk.tkeep = spk_q[0].keep; s_spk.tlast = spk_q[0].last;
    end else begin
      s_spk.tvalid = 1'b0; s_spk.tdata = '0; s_spk.tkeep = '0; s_spk.tlast = 1'b0;
    end
    case (mode)
      0:       m.tready = 1'b1;
      1:       m.tready = ~m.tready;
      default: m.tready = 1'($urandom_range(1));
    endcase
  end

  task automatic mon_clear();
    obs_beats = 0; tik_cnt = 0; tik_w = 0; tik_prev = 0; spk_in_cfg = 0; last_tlast_cyc = 0;
    exp_q.delete(); cfg_q.delete(); spk_q.delete();
  endtask

  // Reference: output is every cfg beat (if enabled) then every spike frame, in source order.
  task automatic load_run(input vec_t v, input int id);
    beat_t b;
    for (int i = 0; i < (v.cfg_en ? v.cb : 2); i++) begin
      b.data = {8'hCF, 8'(id), 16'(i), 32'($urandom)};
      b.keep = 8'($urandom);
      b.last = v.cfg_en ? (i == v.cb - 1) : (i == 1);
      cfg_q.push_back(b);
      if (v.cfg_en) exp_q.push_back(b);
    end
    for (int f = 0; f < v.n; f++)
      for (int i = 0; i < v.sb; i++) begin
        b.data = {8'h5B, 8'(id), 8'(f), 8'(i), 32'($urandom)};
        b.keep = 8'($urandom);
        b.last = (i == v.sb - 1);
        spk_q.push_back(b);
        exp_q.push_back(b);
      end
  endtask

  task automatic pulse_start(input vec_t v);
    @(posedge clk); #2;
    start = 1'b1; cfg_en = v.cfg_en; num_steps = 8'(v.n);
    @(posedge clk); #2;
    start = 1'b0; cfg_en = 1'($urandom); num_steps = 8'($urandom);
  endtask

  task automatic run_case(input vec_t v, input int id);
    bit active;
    active = v.cfg_en || (v.n != 0);
    mon_clear();
    load_run(v, id);
    mode = v.mode;
    mon_en = 1;
    pulse_start(v);
    @(negedge clk);
    check("busy_after_start", busy, active);
    check("done_after_start", done, !active);
    check("step_cnt_cleared", step_cnt, 0);
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      start = v.inject && (i == 3);
      if (start) begin cfg_en = 1'b1; num_steps = 8'd9; end
    end
    start = 1'b0;
    @(negedge clk);
    check("done_reached", done, 1);
    check("busy_end", busy, 0);
    check("m_tvalid_end", m.tvalid, 0);
    check("step_cnt_end", step_cnt, v.n);
    check("beat_count", obs_beats, v.exp_beats);
    check("tik_count", tik_cnt, v.exp_tiks);
    check("exp_drained", exp_q.size(), 0);
    check("spk_left", spk_q.size(), 0);
    check("cfg_left", cfg_q.size(), v.cfg_en ? 0 : 2);
    check("spk_ready_in_cfg", spk_in_cfg, 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_tik"}, tik, 0);
    check({tag, "_step_cnt"}, step_cnt, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_m_tvalid"}, m.tvalid, 0);
    check({tag, "_cfg_tready"}, s_cfg.tready, 0);
    check({tag, "_spk_tready"}, s_spk.tready, 0);
  endtask

  vec_t tbl[6];
  vec_t v;

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_en = 1'b0; num_steps = '0; m.tready = 1'b0;
    s_cfg.tvalid = 1'b0; s_cfg.tdata = '0; s_cfg.tkeep = '0; s_cfg.tlast = 1'b0;
    s_spk.tvalid = 1'b0; s_spk.tdata = '0; s_spk.tkeep = '0; s_spk.tlast = 1'b0;

    //           cfg n  cb sb mode inj beats tiks
    tbl[0] = '{1, 3, 4, 2, 0, 0, 10, 3};
    tbl[1] = '{1, 2, 5, 3, 1, 0, 11, 2};
    tbl[2] = '{0, 0, 1, 1, 0, 0,  0, 0};
    tbl[3] = '{1, 0, 3, 2, 2, 0,  3, 0};
    tbl[4] = '{0, 4, 2, 1, 2, 0,  4, 4};
    tbl[5] = '{1, 2, 3, 2, 0, 1,  7, 2};

    load_run(tbl[4], 99);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset("idle");

    for (int k = 0; k < 6; k++) run_case(tbl[k], k);

    for (int r = 0; r < 8; r++) begin
      v.cfg_en = 1'($urandom_range(1));
      v.n      = $urandom_range(4);
      v.cb     = $urandom_range(5, 1);
      v.sb     = $urandom_range(4, 1);
      v.mode   = $urandom_range(2);
      v.inject = (v.cfg_en || v.n != 0) ? 1'($urandom_range(1)) : 1'b0;
      v.exp_beats = (v.cfg_en ? v.cb : 0) + v.n * v.sb;
      v.exp_tiks  = v.n;
      run_case(v, 16 + r);
    end

    // Asynchronous abort during the second tik, then a clean restart.
    v = '{0, 3, 1, 2, 0, 0, 6, 3};
    mon_clear();
    load_run(v, 40);
    mode = 0;
    mon_en = 1;
    pulse_start(v);
    for (int i = 0; i < 2000 && !(tik_cnt == 1 && tik); i++) @(negedge clk);
    check("reached_tik2", tik, 1);
    mon_en = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("abort");
    @(posedge clk); #3;
    rst_n = 1'b1;
    run_case('{0, 1, 1, 2, 0, 0, 2, 1}, 41);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pcss_step_sched.md
# pcss_step_sched

Timestep scheduler between the host-side stream sources and `pcss_inf`. It multiplexes a configuration AXI-stream and a spike AXI-stream onto the single `S_AXIS_send` input of `pcss_inf`. It sequences one configuration frame followed by N spike frames, and after each spike frame it waits for a drain interval and then drives the `tik` pulse that advances the chip timestep.

## Interface
- `DATA_WIDTH`, 64, stream data width; keep width is DATA_WIDTH/8
- `TIK_CNT`, 8, width of the step counter and of `num_steps`
- `TIK_LEN`, 7, cycles `tik` is held high per step (≥1)
- `DRAIN_CYC`, 16, idle cycles between a spike frame's last beat and `tik` (≥1)

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle run request; sampled only in IDLE or DONE
- `cfg_en`  in  1  sampled with `start`; 1 = send the config frame first
- `num_steps`  in  TIK_CNT  sampled with `start`; number of spike frames/tiks
- `s_cfg_tdata/tvalid/tlast/tkeep`  in  DATA_WIDTH/1/1/DATA_WIDTH/8  config stream
- `s_cfg_tready`  out  1
- `s_spk_tdata/tvalid/tlast/tkeep`  in  same widths  spike stream, one frame per step
- `s_spk_tready`  out  1
- `m_tdata/tvalid/tlast/tkeep`  out  same widths  to `pcss_inf` S_AXIS_send
- `m_tready`  in  1
- `tik`  out  1  registered timestep pulse
- `step_cnt`  out  TIK_CNT  completed tiks in the current run
- `busy`  out  1  high in any state other than IDLE/DONE
- `done`  out  1  high in DONE

## Operation
- States: IDLE, CFG, SPK, DRAIN, TIK, DONE.
- IDLE/DONE, `start`=1: latch `cfg_en`/`num_steps`, clear `step_cnt`, then go to:
  - CFG if `cfg_en`;
  - else SPK if `num_steps`≠0;
  - else DONE.
- CFG: forward the cfg stream.
  - On a beat with `s_cfg_tvalid&m_tready&s_cfg_tlast`: go to SPK if `num_steps`≠0, else DONE.
- SPK: forward the spk stream.
  - On the accepted tlast beat: go to DRAIN.
- DRAIN: wait DRAIN_CYC cycles, then go to TIK.
- TIK: `tik`=1 for TIK_LEN cycles.
  - On the last TIK cycle, `step_cnt`+1.
  - Then go to DONE if the new `step_cnt`==`num_steps`, else SPK.
- Mux rules:
  - The selected source's tdata/tvalid/tlast/tkeep pass through to `m_*` combinationally.
  - Selected tready = `m_tready`.
  - The unselected tready and all of `m_*` are 0 outside CFG/SPK.
- Arithmetic: `step_cnt` never wraps, because the run terminates at `num_steps` (max 2^TIK_CNT−1).
- `start` outside IDLE/DONE is ignored. A latched run is not restartable except by reset.
- DONE holds `done`=1 until the next accepted `start`.

## Timing
- Reset values: state IDLE; `tik`=0; `step_cnt`=0; `busy`=0; `done`=0; `m_tvalid`=0; `s_cfg_tready`=0; `s_spk_tready`=0.
- Async reset mid-run aborts immediately to the reset values. A partially sent frame is abandoned.
- Stream path latency: 0 cycles. AXI rule: `m_tvalid` never depends on `m_tready`.
- `tik` rises on the clock edge that ends the DRAIN_CYC-th DRAIN cycle. It stays high exactly TIK_LEN cycles.
- `step_cnt` updates on the same edge that `tik` falls.
- Minimum step period = frame beats + DRAIN_CYC + TIK_LEN cycles.
- `start` to first `m_tvalid` possible: 1 cycle, because state registers on the `start` edge.
- `m_tready` low stalls the frame with no beat loss. DRAIN starts only after the tlast handshake.
- `tvalid` on a source that is not selected is held off: its tready=0, so no beat is consumed.
- Simultaneous `start` and DONE entry cannot occur, because `start` is sampled only in IDLE/DONE.

## Structure
- `pcss_pkg` holds:
  - the state enum;
  - the default constants `TIK_LEN`=7 and `DRAIN_CYC`=16 (shared with bench tik counting);
  - the `TIK_CNT` default.
- Sub-module `pcss_cyc_timer`: a loadable down-counter with a `load`/`expire` pulse, reused for DRAIN and TIK.
- The stream mux and FSM stay in `pcss_step_sched`.

## Test plan
- `cfg_en`=1, `num_steps`=3, cfg frame 4 beats, spk frames of 2 beats, `m_tready`=1 → the 4 cfg then 2+2+2 spk beats appear in order.
  - 3 `tik` pulses, each 7 cycles wide, each starting 16 cycles after its frame's tlast.
  - `step_cnt` ends at 3; `done`=1.
- `m_tready` toggling 1/0 every cycle during the cfg frame → all beats are delivered once, with no duplicates; DRAIN does not begin before tlast is accepted.
- `cfg_en`=0, `num_steps`=0 → DONE one cycle after `start`; no beats and no `tik`.
- Spike source asserts `tvalid` during CFG → `s_spk_tready`=0 throughout CFG; the spike beat is first consumed in SPK.
- `rst_n` asserted during TIK of step 2 → all outputs take their reset values asynchronously.
  - A new `start` after release restarts with `step_cnt`=0.
- `start` pulsed while `busy` → ignored; `num_steps` keeps its original latched value.
